hammer_sweep_ctrl: RTL and testbench

- Sequential sweep controller for the expression-check harness.
- Drives one shared stimulus vector into two implementations of the same expression module: a reference model instance and an implementation-under-test instance.
- Exhaustively steps the stimulus through all 2^IN_W values, compares the two output vectors under a care mask, and records the mismatch count plus the first failing vector.
- Sits between the bench top and the paired expression instances; the shared stimulus makes it the sole sequencer of the datapath.

---
 rtl/hammer_sweep_ctrl_if.sv | 31 +++
 rtl/hammer_sweep_ctrl.sv | 135 +++++++++++++
 tb/tb_hammer_sweep_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hammer_sweep_ctrl_if.sv
// Stimulus/compare bundle between the bench top and the sweep controller.
// The controller is the slave side; the bench or harness top is the master.
interface hammer_sweep_ctrl_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);
    logic             start;
    logic             abort;
    logic [OUT_W-1:0] y_care;
    logic [OUT_W-1:0] y_ref;
    logic [OUT_W-1:0] y_dut;
    logic [IN_W-1:0]  stim;
    logic             busy;
    logic             done;
    logic [IN_W:0]    mismatch_cnt;
    logic             first_fail_valid;
    logic [IN_W-1:0]  first_fail_vec;
    logic [OUT_W-1:0] first_fail_diff;

    modport master (
        output start, abort, y_care, y_ref, y_dut,
        input  stim, busy, done, mismatch_cnt,
        input  first_fail_valid, first_fail_vec, first_fail_diff
    );

    modport slave (
        input  start, abort, y_care, y_ref, y_dut,
        output stim, busy, done, mismatch_cnt,
        output first_fail_valid, first_fail_vec, first_fail_diff
    );
endinterface

// File: rtl/hammer_sweep_ctrl.sv
// Exhaustive stimulus sweep comparing a reference and a DUT expression
// instance under a care mask; counts failures and keeps the first one.
module hammer_sweep_ctrl #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 16,
    parameter int SETTLE = 2
) (
    input logic               clk,
    input logic               rst_n,
    hammer_sweep_ctrl_if.slave bus_if
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
    localparam logic [IN_W-1:0] STIM_MAX = '1;
    localparam logic [IN_W-1:0] STIM_ONE = IN_W'(1);
    localparam logic [IN_W:0]   CNT_ONE  = (IN_W + 1)'(1);

    state_e           state_q, state_d;
    logic [IN_W-1:0]  stim_q, stim_d;
    logic [3:0]       settle_q, settle_d;
    logic [IN_W:0]    cnt_q, cnt_d;
    logic             ffv_q, ffv_d;
    logic [IN_W-1:0]  ffvec_q, ffvec_d;
    logic [OUT_W-1:0] ffdiff_q, ffdiff_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [OUT_W-1:0] diff;

    assign diff = (bus_if.y_ref ^ bus_if.y_dut) & bus_if.y_care;

    always_comb begin
        state_d  = state_q;
        stim_d   = stim_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;
        ffdiff_d = ffdiff_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus_if.start) begin
                    stim_d   = '0;
                    cnt_d    = '0;
                    ffv_d    = 1'b0;
                    ffvec_d  = '0;
                    ffdiff_d = '0;
                    state_d  = S_APPLY;
                end
            end
            S_APPLY: begin
                if (bus_if.abort) begin
                    state_d = S_DONE;
                end else if (SETTLE_L == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = SETTLE_L;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_if.abort) begin
                    state_d = S_DONE;
                end else if (settle_q <= 4'd1) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_CHECK: begin
                // an abort here drops the sample without touching results
                if (bus_if.abort) begin
                    state_d = S_DONE;
                end else begin
                    if (|diff) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (!ffv_q) begin
                            ffv_d    = 1'b1;
                            ffvec_d  = stim_q;
                            ffdiff_d = diff;
                        end
                    end
                    if (stim_q == STIM_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        stim_d  = stim_q + STIM_ONE;
                        state_d = S_APPLY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_APPLY) || (state_d == S_WAIT) ||
                 (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            stim_q   <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            ffdiff_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stim_q   <= stim_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
            ffdiff_q <= ffdiff_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus_if.stim             = stim_q;
    assign bus_if.busy             = busy_q;
    assign bus_if.done             = done_q;
    assign bus_if.mismatch_cnt     = cnt_q;
    assign bus_if.first_fail_valid = ffv_q;
    assign bus_if.first_fail_vec   = ffvec_q;
    assign bus_if.first_fail_diff  = ffdiff_q;
endmodule

// File: tb/tb_hammer_sweep_ctrl.sv
// Bench for hammer_sweep_ctrl: two instances (SETTLE=0 and SETTLE=3)
// with sweep results checked against a queue of expected outcomes.
module tb_hammer_sweep_ctrl;
    localparam int IW = 2;
    localparam int OW = 4;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hammer_sweep_ctrl_if #(.IN_W(IW), .OUT_W(OW)) ia (), ib ();

    hammer_sweep_ctrl #(.IN_W(IW), .OUT_W(OW), .SETTLE(0)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(ia.slave)
    );

    hammer_sweep_ctrl #(.IN_W(IW), .OUT_W(OW), .SETTLE(3)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(ib.slave)
    );

    int            mode_a;
    logic [OW-1:0] care_a;
    logic          noisy_b;

    function automatic logic [OW-1:0] flip(int m, logic [IW-1:0] v);
        case (m)
            1:       return (v == 2'd2) ? 4'b0001 : 4'b0000;
            2:       return 4'b1000;
            3:       return (v == 2'd1) ? 4'b0010 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    // paired expression instances modelled around the shared stim
    always_comb begin
        ia.y_ref  = {~ia.stim, ia.stim};
        ia.y_dut  = ia.y_ref ^ flip(mode_a, ia.stim);
        ia.y_care = care_a;
        ib.y_ref  = {ib.stim, ib.stim};
        ib.y_dut  = ib.y_ref ^ {3'b000, noisy_b};
        ib.y_care = 4'hF;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int lat;
        int cnt;
        int val;
        int vec;
        int diff;
        int stim;
    } exp_t;

    exp_t sbq[$];

    function automatic exp_t model(int m, logic [OW-1:0] care, int spc);
        exp_t e;
        logic [OW-1:0] d;
        e.lat = N * spc;
        e.cnt = 0;
        e.val = 0;
        e.vec = 0;
        e.diff = 0;
        e.stim = N - 1;
        for (int v = 0; v < N; v++) begin
            d = flip(m, v[IW-1:0]) & care;
            if (d != 0) begin
                if (e.val == 0) begin
                    e.val = 1;
                    e.vec = v;
                    e.diff = int'(d);
                end
                e.cnt++;
            end
        end
        return e;
    endfunction

    task automatic rd(input bit b, output int dn, output int bs,
                      output int st, output int cnt, output int val,
                      output int vec, output int diff);
        if (b) begin
            dn = int'(ib.done); bs = int'(ib.busy); st = int'(ib.stim);
            cnt = int'(ib.mismatch_cnt); val = int'(ib.first_fail_valid);
            vec = int'(ib.first_fail_vec); diff = int'(ib.first_fail_diff);
        end else begin
            dn = int'(ia.done); bs = int'(ia.busy); st = int'(ia.stim);
            cnt = int'(ia.mismatch_cnt); val = int'(ia.first_fail_valid);
            vec = int'(ia.first_fail_vec); diff = int'(ia.first_fail_diff);
        end
    endtask

    task automatic set_in(input bit b, input logic st, input logic ab);
        if (b) begin
            ib.start = st; ib.abort = ab;
        end else begin
            ia.start = st; ia.abort = ab;
        end
    endtask

    task automatic sweep(input bit b, input string nm,
                         input int abort_e, input int poke_e);
        int spc, e, dn, bs, st, cnt, val, vec, diff;
        exp_t ex;
        spc = b ? 5 : 2;
        @(negedge clk);
        set_in(b, 1'b1, 1'b0);
        @(negedge clk);
        set_in(b, 1'b0, 1'b0);
        e = 1;
        forever begin
            rd(b, dn, bs, st, cnt, val, vec, diff);
            if (dn != 0) break;
            if (e > 200) begin
                check({nm, "_timeout"}, e, -1);
                break;
            end
            check({nm, "_busy"}, bs, 1);
            check({nm, "_stim"}, st, (e - 1) / spc);
            if (b) noisy_b = ((e - 1) % spc) inside {1, 2, 3};
            set_in(b, e == poke_e, e == abort_e);
            @(negedge clk);
            e++;
        end
        noisy_b = 1'b0;
        set_in(b, 1'b0, 1'b0);
        if (sbq.size() == 0) begin
            check({nm, "_sb_empty"}, 1, 0);
        end else begin
            ex = sbq.pop_front();
            rd(b, dn, bs, st, cnt, val, vec, diff);
            check({nm, "_lat"}, e - 1, ex.lat);
            check({nm, "_busy_end"}, bs, 0);
            check({nm, "_stim_end"}, st, ex.stim);
            check({nm, "_cnt"}, cnt, ex.cnt);
            check({nm, "_ffv"}, val, ex.val);
            check({nm, "_ffvec"}, vec, ex.vec);
            check({nm, "_ffdiff"}, diff, ex.diff);
        end
    endtask

    initial begin
        int dn, bs, st, cnt, val, vec, diff, k;
        exp_t ab;
        ia.start = 1'b0; ia.abort = 1'b0;
        ib.start = 1'b0; ib.abort = 1'b0;
        mode_a = 0; care_a = 4'hF; noisy_b = 1'b0;
        repeat (2) @(negedge clk);
        rd(1'b0, dn, bs, st, cnt, val, vec, diff);
        check("rst_done", dn, 0);
        check("rst_busy", bs, 0);
        check("rst_stim", st, 0);
        check("rst_cnt", cnt, 0);
        check("rst_ffv", val, 0);
        check("rst_ffvec", vec, 0);
        check("rst_ffdiff", diff, 0);
        rst_n = 1'b1;

        mode_a = 0; care_a = 4'hF;
        sbq.push_back(model(0, 4'hF, 2));
        sweep(1'b0, "clean", 0, 3);

        mode_a = 1;
        sbq.push_back(model(1, 4'hF, 2));
        sweep(1'b0, "one_fail", 0, 0);

        ab = '{lat: 4, cnt: 0, val: 0, vec: 0, diff: 0, stim: 1};
        mode_a = 3;
        sbq.push_back(ab);
        sweep(1'b0, "abort", 4, 0);
        sbq.push_back(model(3, 4'hF, 2));
        sweep(1'b0, "restart", 0, 0);

        mode_a = 2; care_a = 4'b0111;
        sbq.push_back(model(2, 4'b0111, 2));
        sweep(1'b0, "masked", 0, 0);
        care_a = 4'hF;
        sbq.push_back(model(2, 4'hF, 2));
        sweep(1'b0, "all_fail", 0, 0);

        sbq.push_back(model(0, 4'hF, 5));
        sweep(1'b1, "settle", 0, 0);

        mode_a = 0;
        @(negedge clk);
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        k = 0;
        while (ia.stim != 2'd2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_reach", int'(ia.stim), 2);
        #2 rst_n = 1'b0;
        #1;
        rd(1'b0, dn, bs, st, cnt, val, vec, diff);
        check("rst_mid_busy", bs, 0);
        check("rst_mid_done", dn, 0);
        check("rst_mid_stim", st, 0);
        check("rst_mid_cnt", cnt + val + vec + diff, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rd(1'b0, dn, bs, st, cnt, val, vec, diff);
        check("post_rst_busy", bs, 0);
        check("post_rst_done", dn, 0);
        check("post_rst_stim", st, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
